// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Dual-slot instruction fetch stage feeding the instruction buffer.
//   Generates the fetch PC, issues one aligned 64-bit request at a time to
//   instruction memory, splits each response into up to two instructions with
//   pc/npc and hands them to the buffer with a one-cycle issue pulse. Branch
//   redirects from execute discard any wrong-path fetch in flight.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   branch_flag/pc    : single-cycle redirect request and its 4-byte aligned target
//   instbuf_full      : buffer cannot accept a packet this cycle
//   imem_req/addr     : memory request valid and 8-byte aligned address
//   imem_gnt          : request accepted this cycle
//   imem_rvalid/rdata : response valid; [31:0]=word at addr, [63:32]=word at addr+4
//   if1_* / if2_*     : slot-1 / slot-2 instruction, pc and next pc
//   issue             : {slot1, slot2} valid pulse for one cycle per packet
//   stop              : buffer must not update from fetch (issue == 2'b00)
//
// Configuration
//   STATIC_JAL_PREDICT_EN : when defined, JAL instructions in a packet are
//   predicted taken; npc and the next fetch pc follow the J-immediate target.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_flag,
    input  logic [31:0] branch_pc,
    input  logic        instbuf_full,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic [31:0] if1_inst,
    output logic [31:0] if1_pc,
    output logic [31:0] if1_npc,
    output logic [31:0] if2_inst,
    output logic [31:0] if2_pc,
    output logic [31:0] if2_npc,
    output logic [1:0]  issue,
    output logic        stop
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DRAIN} state_t;

    typedef struct packed {
        logic [31:0] i1, p1, n1;
        logic [31:0] i2, p2, n2;
        logic [1:0]  issue;
    } pkt_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    pkt_t        pkt, pkt_built;
    logic        pkt_load;
    logic [31:0] base, next_built;
    logic [31:0] step1, step2;
    logic        slot1_jal;

`ifdef STATIC_JAL_PREDICT_EN
    localparam logic [6:0] OP_JAL = 7'b1101111;

    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    assign slot1_jal = (imem_rdata[6:0] == OP_JAL);
    assign step1     = slot1_jal ? j_imm(imem_rdata[31:0]) : 32'd4;
    assign step2     = (imem_rdata[38:32] == OP_JAL) ? j_imm(imem_rdata[63:32]) : 32'd4;
`else
    assign slot1_jal = 1'b0;
    assign step1     = 32'd4;
    assign step2     = 32'd4;
`endif

    // Packet builder: works on the response data and the pc of the request.
    // A fetch at pc[2]=1 starts mid-block, so only the upper word is valid.
    // A predicted slot-1 JAL makes slot 2 wrong-path, so it is dropped.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        base         = {pc[31:3], 3'b000};
        pkt_built    = '0;
        pkt_built.i2 = imem_rdata[63:32];
        pkt_built.p2 = base + 32'd4;
        pkt_built.n2 = pkt_built.p2 + step2;
        next_built   = pkt_built.n2;
        pkt_built.issue = 2'b01;
        if (!pc[2]) begin
            pkt_built.i1 = imem_rdata[31:0];
            pkt_built.p1 = base;
            pkt_built.n1 = base + step1;
            if (slot1_jal) begin
                pkt_built.i2    = '0;
                pkt_built.p2    = '0;
                pkt_built.n2    = '0;
                pkt_built.issue = 2'b10;
                next_built      = pkt_built.n1;
            end else begin
                pkt_built.issue = 2'b11;
            end
        end
    end

    // Next-state logic. A redirect always wins the pc update; the state
    // decisions below only decide whether an in-flight response must still
    // be waited for (DRAIN) before the redirected fetch can start.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pkt_load  = 1'b0;
        unique case (state)
            S_REQ: begin
                if (imem_gnt)
                    state_nxt = branch_flag ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (branch_flag) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_OUT;
                        pkt_load  = 1'b1;
                        pc_nxt    = next_built;
                    end
                end else if (branch_flag) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_OUT: begin
                if (branch_flag || !instbuf_full)
                    state_nxt = S_REQ;
            end
            S_DRAIN: begin
                if (imem_rvalid)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
        if (branch_flag)
            pc_nxt = branch_pc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            pkt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (pkt_load)
                pkt <= pkt_built;
        end
    end

    // The request is held off while reset is asserted even though the state
    // register already sits in REQ.
    assign imem_req  = rst_n && (state == S_REQ);
    assign imem_addr = {pc[31:3], 3'b000};

    assign issue = (state == S_OUT && !instbuf_full && !branch_flag) ? pkt.issue : 2'b00;
    assign stop  = (issue == 2'b00);

    assign if1_inst = pkt.i1;
    assign if1_pc   = pkt.p1;
    assign if1_npc  = pkt.n1;
    assign if2_inst = pkt.i2;
    assign if2_pc   = pkt.p2;
    assign if2_npc  = pkt.n2;

endmodule
